// File: rtl/mem_arbiter.sv
// Three-requester byte-serial memory arbiter (MMIO > DCache > ICache), one RAM byte per cycle.
// Optional macro ARB_STARVE_GUARD_EN lets a waiting ICache win after STARVE_LIMIT DCache grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clkIn,
  input  logic         resetIn,
  input  logic [2:0]   reqValid,
  input  logic [2:0]   reqWrite,
  input  logic [95:0]  reqAddr,
  input  logic [11:0]  reqLenM1,
  input  logic [383:0] reqData,
  output logic [2:0]   grant,
  output logic [2:0]   done,
  output logic [127:0] rdataOut,
  input  logic [7:0]   memIn,
  output logic [31:0]  memAddr,
  output logic [7:0]   memOut,
  output logic         readWriteOut
);
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 4;
  localparam int unsigned DW = 128;
  localparam int unsigned CW = 5;

  typedef enum logic {IDLE, XFER} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      win_q, win_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wr_q, wr_d;
  logic [LW-1:0]   len_q, len_d;
  logic [DW-1:0]   data_q, data_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      done_q, done_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]      mem_out_q, mem_out_d;
  logic            rw_q, rw_d;

  logic [1:0]      pick_c;
  logic            starve_hit_c;
  logic [CW-1:0]   n_c;
  logic [3:0]      rd_idx_c;
  logic [3:0]      wr_idx_c;

  assign n_c      = {1'b0, len_q} + 5'd1;
  assign rd_idx_c = 4'(cnt_q - 5'd1);
  assign wr_idx_c = 4'(cnt_q);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign starve_hit_c = (starve_q == SW'(STARVE_LIMIT));

  // Count DCache grants that bypass a waiting ICache; any ICache grant or idle ICache clears it.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!reqValid[2] || pick_c == 2'd2) starve_d = '0;
      else if (pick_c == 2'd1)            starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clkIn) begin
    if (!resetIn) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`else
  logic unused_limit;
  assign starve_hit_c = 1'b0;
  assign unused_limit = ^STARVE_LIMIT;
`endif

  // Fixed priority; MMIO is never overridden by the starvation guard.
  always_comb begin
    pick_c = 2'd0;
    if (reqValid[0])                                 pick_c = 2'd0;
    else if (reqValid[1] && !(reqValid[2] && starve_hit_c)) pick_c = 2'd1;
    else if (reqValid[2])                            pick_c = 2'd2;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    len_d      = len_q;
    data_d     = data_q;
    grant_d    = '0;
    done_d     = '0;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_out_d  = mem_out_q;
    rw_d       = rw_q;
    unique case (state_q)
      IDLE: begin
        mem_addr_d = '0;
        rw_d       = 1'b0;
        if (|reqValid) begin
          state_d         = XFER;
          cnt_d           = 5'd1;
          win_d           = pick_c;
          addr_d          = reqAddr[AW*int'(pick_c) +: AW];
          wr_d            = reqWrite[pick_c];
          len_d           = reqLenM1[LW*int'(pick_c) +: LW];
          data_d          = reqData[DW*int'(pick_c) +: DW];
          mem_addr_d      = reqAddr[AW*int'(pick_c) +: AW];
          rw_d            = reqWrite[pick_c];
          mem_out_d       = reqData[DW*int'(pick_c) +: 8];
          grant_d[pick_c] = 1'b1;
          if (!reqWrite[pick_c]) rdata_d = '0;
        end
      end
      XFER: begin
        // memIn answers the address driven during the cycle that just ended.
        if (!wr_q) rdata_d[{rd_idx_c, 3'b000} +: 8] = memIn;
        if (cnt_q == n_c) begin
          state_d        = IDLE;
          mem_addr_d     = '0;
          rw_d           = 1'b0;
          done_d[win_q]  = 1'b1;
        end else begin
          cnt_d      = cnt_q + 5'd1;
          mem_addr_d = addr_q + AW'(cnt_q);
          if (wr_q) mem_out_d = data_q[{wr_idx_c, 3'b000} +: 8];
        end
      end
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      win_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      len_q      <= '0;
      data_q     <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_out_q  <= '0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      len_q      <= len_d;
      data_q     <= data_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_out_q  <= mem_out_d;
      rw_q       <= rw_d;
    end
  end

  assign grant        = grant_q;
  assign done         = done_q;
  assign rdataOut     = rdata_q;
  assign memAddr      = mem_addr_q;
  assign memOut       = mem_out_q;
  assign readWriteOut = rw_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level expected-trace model plus directed scenarios.
// RAM model returns the low byte of the address driven in the previous cycle.
module tb_mem_arbiter;
  localparam int unsigned STARVE_LIMIT = 4;

  logic         clkIn = 1'b0;
  logic         resetIn;
  logic [2:0]   reqValid;
  logic [2:0]   reqWrite;
  logic [95:0]  reqAddr;
  logic [11:0]  reqLenM1;
  logic [383:0] reqData;
  logic [2:0]   grant;
  logic [2:0]   done;
  logic [127:0] rdataOut;
  logic [7:0]   memIn;
  logic [31:0]  memAddr;
  logic [7:0]   memOut;
  logic         readWriteOut;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clkIn(clkIn), .resetIn(resetIn), .reqValid(reqValid), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqLenM1(reqLenM1), .reqData(reqData), .grant(grant),
    .done(done), .rdataOut(rdataOut), .memIn(memIn), .memAddr(memAddr),
    .memOut(memOut), .readWriteOut(readWriteOut)
  );

  always #5 clkIn = ~clkIn;
  assign memIn = memAddr[7:0];

  typedef struct packed {
    logic [2:0]   grant;
    logic [2:0]   done;
    logic [31:0]  addr;
    logic         rw;
    logic [7:0]   mout;
    logic [127:0] rdata;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit m_valid  = 1'b0;
  int m_starve = 0;
  exp_t m_exp  = '0;
  exp_t m_q[$];

  int          grant_log[$];
  logic [31:0] addr_log[$];
  logic [7:0]  out_log[$];
  logic        rw_log[$];
  int          grant_cyc[3];
  int          done_cyc[3];
  int          done_cnt[3];
  bit          log_on = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [2:0] v);
    if (v[0]) return 0;
    if (v[1]) return 1;
    return 2;
  endfunction

  function automatic int model_pick(input logic [2:0] v);
    if (v[0]) return 0;
`ifdef ARB_STARVE_GUARD_EN
    if (v[1] && v[2] && m_starve == int'(STARVE_LIMIT)) return 2;
`endif
    if (v[1]) return 1;
    return 2;
  endfunction

  // Precompute the whole per-cycle output trace of an accepted transfer.
  task automatic build(input int w);
    exp_t r;
    logic [31:0] a;
    logic [127:0] d;
    logic [127:0] rd;
    logic wr;
    int n;
    a  = reqAddr[32*w +: 32];
    d  = reqData[128*w +: 128];
    wr = reqWrite[w];
    n  = int'(reqLenM1[4*w +: 4]) + 1;
    rd = wr ? m_exp.rdata : '0;
    for (int j = 0; j <= n; j++) begin
      r = '0;
      if (j == 0) r.grant = 3'(1 << w);
      if (j == n) r.done  = 3'(1 << w);
      r.addr = (j == n) ? 32'h0 : a + 32'(j);
      r.rw   = (j == n) ? 1'b0 : wr;
      r.mout = wr ? d[8*((j < n) ? j : n - 1) +: 8] : d[7:0];
      if (!wr && j > 0) rd[8*(j-1) +: 8] = 8'(a + 32'(j - 1));
      r.rdata = rd;
      m_q.push_back(r);
    end
  endtask

  // Behavioural model: a pending trace is busy time; otherwise arbitrate.
  initial forever begin
    @(posedge clkIn);
    cyc++;
    if (!resetIn) begin
      m_q.delete();
      m_exp    = '0;
      m_starve = 0;
      m_valid  = 1'b1;
    end else if (m_q.size() != 0) begin
      m_exp = m_q.pop_front();
    end else if (reqValid != 3'b000) begin
      int w;
      w = model_pick(reqValid);
      if (!reqValid[2] || w == 2) m_starve = 0;
      else if (w == 1)           m_starve++;
      build(w);
      m_exp = m_q.pop_front();
    end else begin
      m_starve    = 0;
      m_exp.grant = '0;
      m_exp.done  = '0;
      m_exp.addr  = '0;
      m_exp.rw    = 1'b0;
    end
  end

  // Compare every cycle, then log DUT events for the directed checks.
  initial forever begin
    @(posedge clkIn);
    #1;
    if (m_valid) begin
      check("grant",        128'(grant),        128'(m_exp.grant));
      check("done",         128'(done),         128'(m_exp.done));
      check("memAddr",      128'(memAddr),      128'(m_exp.addr));
      check("readWriteOut", 128'(readWriteOut), 128'(m_exp.rw));
      check("memOut",       128'(memOut),       128'(m_exp.mout));
      check("rdataOut",     rdataOut,           m_exp.rdata);
    end
    if (!resetIn) log_on = 1'b0;
    if (|grant) begin
      log_on = 1'b1;
      grant_log.push_back(oh_idx(grant));
      grant_cyc[oh_idx(grant)] = cyc;
    end
    if (|done) begin
      log_on = 1'b0;
      done_cyc[oh_idx(done)] = cyc;
      done_cnt[oh_idx(done)]++;
    end
    if (log_on) begin
      addr_log.push_back(memAddr);
      out_log.push_back(memOut);
      rw_log.push_back(readWriteOut);
    end
  end

  task automatic clear_logs();
    grant_log.delete();
    addr_log.delete();
    out_log.delete();
    rw_log.delete();
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                         input logic [3:0] l, input logic [127:0] d);
    reqWrite[i]          = wr;
    reqAddr[32*i +: 32]  = a;
    reqLenM1[4*i +: 4]   = l;
    reqData[128*i +: 128] = d;
    reqValid[i]          = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    int n = 0;
    while (grant[i] !== 1'b1 && n < 60) begin
      @(negedge clkIn);
      n++;
    end
    if (grant[i] !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_grant%0d: no grant within 60 cycles", i);
    end
    reqValid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    do begin
      @(negedge clkIn);
      n++;
    end while (done[i] !== 1'b1 && n < 60);
    if (done[i] !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done%0d: no done within 60 cycles", i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetIn  = 1'b0;
    reqValid = '0;
    reqWrite = '0;
    reqAddr  = '0;
    reqLenM1 = '0;
    reqData  = '0;
    repeat (3) @(negedge clkIn);
    check("rst_grant",   128'(grant),   128'h0);
    check("rst_memAddr", 128'(memAddr), 128'h0);
    check("rst_rdata",   rdataOut,      128'h0);
    resetIn = 1'b1;
    @(negedge clkIn);

    // ICache 16-byte read; a short-lived MMIO request and field changes mid-transfer are ignored.
    clear_logs();
    set_req(2, 1'b0, 32'h0000_1230, 4'd15, '0);
    wait_grant(2);
    reqAddr[95:64] = 32'hDEAD_BEEF;
    reqValid[0] = 1'b1;
    repeat (3) @(negedge clkIn);
    reqValid[0] = 1'b0;
    wait_done(2);
    check("r032_latency", 128'(done_cyc[2] - grant_cyc[2]), 128'd16);
    check("r032_rdata",   rdataOut, 128'h3F3E3D3C3B3A39383736353433323130);
    check("r032_model",   m_exp.rdata, 128'h3F3E3D3C3B3A39383736353433323130);
    check("r032_naddr",   128'(addr_log.size()), 128'd16);
    for (int k = 0; k < 16; k++) check("r032_addr", 128'(addr_log[k]), 128'(32'h1230 + k));
    check("r032_grants",  128'(grant_log.size()), 128'd1);

    // DCache 4-byte write; rdataOut must keep the previous read result.
    @(negedge clkIn);
    clear_logs();
    set_req(1, 1'b1, 32'h0000_0100, 4'd3, 128'hDDCCBBAA);
    wait_grant(1);
    wait_done(1);
    check("r033_latency", 128'(done_cyc[1] - grant_cyc[1]), 128'd4);
    for (int k = 0; k < 4; k++) begin
      check("r033_addr", 128'(addr_log[k]), 128'(32'h100 + k));
      check("r033_rw",   128'(rw_log[k]),   128'd1);
    end
    check("r033_out0", 128'(out_log[0]), 128'hAA);
    check("r033_out1", 128'(out_log[1]), 128'hBB);
    check("r033_out2", 128'(out_log[2]), 128'hCC);
    check("r033_out3", 128'(out_log[3]), 128'hDD);
    check("r033_done_addr", 128'(memAddr), 128'h0);
    check("r033_done_rw",   128'(readWriteOut), 128'h0);
    check("r033_rdata_hold", rdataOut, 128'h3F3E3D3C3B3A39383736353433323130);

    // All three request at once.
    @(negedge clkIn);
    clear_logs();
    set_req(0, 1'b1, 32'h0000_0040, 4'd0, 128'h77);
    set_req(1, 1'b0, 32'h0000_0200, 4'd1, '0);
    set_req(2, 1'b0, 32'h0000_0300, 4'd2, '0);
    wait_grant(0);
    wait_grant(1);
    wait_grant(2);
    wait_done(2);
    check("r034_g0", 128'(grant_log[0]), 128'd0);
    check("r034_g1", 128'(grant_log[1]), 128'd1);
    check("r034_g2", 128'(grant_log[2]), 128'd2);
    check("r034_n1_latency", 128'(done_cyc[0] - grant_cyc[0]), 128'd1);
    check("r034_gap01", 128'(grant_cyc[1] - done_cyc[0]), 128'd1);
    check("r034_gap12", 128'(grant_cyc[2] - done_cyc[1]), 128'd1);
    check("r034_rdata", rdataOut, 128'h020100);

    // Address wrap at 2^32.
    @(negedge clkIn);
    clear_logs();
    set_req(1, 1'b0, 32'hFFFF_FFFE, 4'd3, '0);
    wait_grant(1);
    wait_done(1);
    check("r035_a0", 128'(addr_log[0]), 128'hFFFF_FFFE);
    check("r035_a1", 128'(addr_log[1]), 128'hFFFF_FFFF);
    check("r035_a2", 128'(addr_log[2]), 128'h0000_0000);
    check("r035_a3", 128'(addr_log[3]), 128'h0000_0001);
    check("r035_rdata", rdataOut, 128'h0100FFFE);

    // Reset in cycle 5 of a 16-byte read, then an immediate new request.
    @(negedge clkIn);
    set_req(2, 1'b0, 32'h0000_2000, 4'd15, '0);
    wait_grant(2);
    repeat (4) @(negedge clkIn);
    resetIn = 1'b0;
    @(negedge clkIn);
    check("r036_grant", 128'(grant),        128'h0);
    check("r036_done",  128'(done),         128'h0);
    check("r036_addr",  128'(memAddr),      128'h0);
    check("r036_out",   128'(memOut),       128'h0);
    check("r036_rw",    128'(readWriteOut), 128'h0);
    check("r036_rdata", rdataOut,           128'h0);
    resetIn = 1'b1;
    set_req(1, 1'b0, 32'h0000_0055, 4'd0, '0);
    @(negedge clkIn);
    check("r036_regrant", 128'(grant), 128'b010);
    reqValid[1] = 1'b0;
    wait_done(1);
    check("r036_rdata2", rdataOut, 128'h55);
    check("r036_no_icache_done", 128'(done_cnt[2]), 128'd2);

    // DCache and ICache both requesting continuously.
    @(negedge clkIn);
    clear_logs();
    set_req(1, 1'b0, 32'h0000_0010, 4'd0, '0);
    set_req(2, 1'b0, 32'h0000_0020, 4'd0, '0);
    n = 0;
    while (grant_log.size() < 5 && n < 60) begin
      @(negedge clkIn);
      n++;
    end
    reqValid = '0;
    check("r037_count", 128'(grant_log.size()), 128'd5);
    for (int k = 0; k < 5; k++) begin
      int e;
      e = 1;
`ifdef ARB_STARVE_GUARD_EN
      if (k == 4) e = 2;
`endif
      check("r037_grant", 128'(grant_log[k]), 128'(e));
    end
    repeat (4) @(negedge clkIn);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
